load_store_unit: RTL and testbench

Sequencer between the core's execute stage and the word-organised data memory. Accepts one load or store request at a time and checks alignment and range. Drives the memory's chip-select, active-low write enable, read enable and byte mask, then returns sign- or zero-extended load data or store completion through a valid/ready handshake.

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store sequencer for a word-organised data memory
module load_store_unit #(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic        mem_chip_select,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic        mem_cs_q, mem_cs_d;

  logic        accept;
  logic        bad_f3, misaligned, out_of_range, req_err;
  logic [31:0] shifted, load_fmt;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    if (req_store) bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else           bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= MEM_LIMIT);
    req_err      = bad_f3 || misaligned || out_of_range;
  end

  // Memory word arrives whole; move the addressed lane down before extending.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_fmt = shifted;
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_mask_q   <= 4'b0000;
      mem_wr_en_q  <= 1'b1;
      mem_rd_en_q  <= 1'b0;
      mem_cs_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_cs_q     <= mem_cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory controls default to idle every cycle; only the accept edge opens an access.
  always_comb begin
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = 4'b0000;
    mem_wr_en_d  = 1'b1;
    mem_rd_en_d  = 1'b0;
    mem_cs_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            mem_cs_d   = 1'b0;
            if (req_store) begin
              mem_wr_en_d = 1'b0;
              case (req_funct3[1:0])
                2'b00: begin
                  mem_wdata_d = {4{req_wdata[7:0]}};
                  mem_mask_d  = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                  mem_wdata_d = {2{req_wdata[15:0]}};
                  mem_mask_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  mem_wdata_d = req_wdata;
                  mem_mask_d  = 4'b1111;
                end
              endcase
            end else begin
              mem_rd_en_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = store_q ? 32'h0 : load_fmt;
      end
      default: ;
    endcase
  end

  assign resp_valid      = resp_valid_q;
  assign resp_err        = resp_err_q;
  assign resp_rdata      = resp_rdata_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_mask        = mem_mask_q;
  assign mem_wr_en       = mem_wr_en_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_chip_select = mem_cs_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a negedge-sampling memory model
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic        mem_chip_select;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(512)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_chip_select(mem_chip_select),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  int cyc;
  int cs_low_cnt;
  int wr_low_cnt;
  int errors;
  int checks;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!mem_chip_select) begin
      cs_low_cnt++;
      if (!mem_wr_en) begin
        wr_low_cnt++;
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_addr[10:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (mem_rd_en) mem_rdata = mem[mem_addr[10:2]];
    end
  end

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int g;
    g = 0;
    while (!req_ready && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL %s_ready_timeout: got 0 expected 1", name);
    end
  endtask

  task automatic run_req(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    wait_ready(name);
    cs_low_cnt = 0;
    wr_low_cnt = 0;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, exp_err ? 0 : 1);
    chk({name, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
    chk({name, "_rdata"}, resp_rdata, exp_rdata);
    chk({name, "_cs"}, cs_low_cnt, exp_err ? 0 : 1);
    chk({name, "_wr"}, wr_low_cnt, (st && !exp_err) ? 1 : 0);
  endtask

  logic        tp_st [4];
  logic [31:0] tp_addr [4];
  logic [31:0] tp_wd [4];
  int          acc_t [4];
  logic [31:0] resp_q[$];

  initial begin
    int i, guard;
    logic rdy;
    errors = 0; checks = 0; cyc = 0;
    cs_low_cnt = 0; wr_low_cnt = 0;
    mem_rdata = 32'h0;
    for (int k = 0; k < 512; k++) mem[k] = 32'h0;
    mem[0]   = 32'hF00D8001;
    mem[2]   = 32'h80FF7F01;
    mem[511] = 32'h13572468;

    reset = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_mask", {28'h0, mem_mask}, 32'h0);
    chk("rst_wr_en", {31'h0, mem_wr_en}, 32'h1);
    chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("rst_cs", {31'h0, mem_chip_select}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{"lb_9",     1'b0, 3'b000, 32'h9,   32'h0,        1'b0, 32'h0000007F});
    vecs.push_back('{"lb_b",     1'b0, 3'b000, 32'hB,   32'h0,        1'b0, 32'hFFFFFF80});
    vecs.push_back('{"lbu_b",    1'b0, 3'b100, 32'hB,   32'h0,        1'b0, 32'h00000080});
    vecs.push_back('{"lb_8",     1'b0, 3'b000, 32'h8,   32'h0,        1'b0, 32'h00000001});
    vecs.push_back('{"lh_8",     1'b0, 3'b001, 32'h8,   32'h0,        1'b0, 32'h00007F01});
    vecs.push_back('{"lbu_a",    1'b0, 3'b100, 32'hA,   32'h0,        1'b0, 32'h000000FF});
    vecs.push_back('{"lhu_2",    1'b0, 3'b101, 32'h2,   32'h0,        1'b0, 32'h0000F00D});
    vecs.push_back('{"lh_2",     1'b0, 3'b001, 32'h2,   32'h0,        1'b0, 32'hFFFFF00D});
    vecs.push_back('{"lw_7fc",   1'b0, 3'b010, 32'h7FC, 32'h0,        1'b0, 32'h13572468});
    vecs.push_back('{"lw_6",     1'b0, 3'b010, 32'h6,   32'h0,        1'b1, 32'h0});
    vecs.push_back('{"sh_5",     1'b1, 3'b001, 32'h5,   32'h1234,     1'b1, 32'h0});
    vecs.push_back('{"ld_f3_3",  1'b0, 3'b011, 32'h0,   32'h0,        1'b1, 32'h0});
    vecs.push_back('{"lw_800",   1'b0, 3'b010, 32'h800, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{"st_f3_4",  1'b1, 3'b100, 32'h0,   32'h55,       1'b1, 32'h0});
    vecs.push_back('{"lh_1",     1'b0, 3'b001, 32'h1,   32'h0,        1'b1, 32'h0});
    vecs.push_back('{"sb_1",     1'b1, 3'b000, 32'h1,   32'h000000AA, 1'b0, 32'h0});
    vecs.push_back('{"lw_0",     1'b0, 3'b010, 32'h0,   32'h0,        1'b0, 32'hF00DAA01});
    vecs.push_back('{"sw_4",     1'b1, 3'b010, 32'h4,   32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{"lw_4",     1'b0, 3'b010, 32'h4,   32'h0,        1'b0, 32'hDEADBEEF});

    foreach (vecs[v])
      run_req(vecs[v].name, vecs[v].st, vecs[v].f3, vecs[v].addr, vecs[v].wdata,
              vecs[v].err, vecs[v].rdata);

    // SH to the upper half of word 2, inspected while the access is on the bus
    wait_ready("sh_a");
    wr_low_cnt = 0;
    req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'hA; req_wdata = 32'h1234ABCD;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sh_a_mask", {28'h0, mem_mask}, 32'h0000000C);
    chk("sh_a_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_a_addr", mem_addr, 32'h8);
    chk("sh_a_wr_en", {31'h0, mem_wr_en}, 32'h0);
    chk("sh_a_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("sh_a_resp", {31'h0, resp_valid}, 32'h1);
    chk("sh_a_wr_off", {31'h0, mem_wr_en}, 32'h1);
    @(posedge clk); #1;
    chk("sh_a_pulse", {31'h0, resp_valid}, 32'h0);
    chk("sh_a_wr_cnt", wr_low_cnt, 1);
    run_req("lw_8", 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hABCD7F01);

    // Back-to-back SW/LW with req_valid held high
    tp_st[0] = 1'b1; tp_addr[0] = 32'h28; tp_wd[0] = 32'h11112222;
    tp_st[1] = 1'b0; tp_addr[1] = 32'h28; tp_wd[1] = 32'h0;
    tp_st[2] = 1'b1; tp_addr[2] = 32'h2C; tp_wd[2] = 32'h33334444;
    tp_st[3] = 1'b0; tp_addr[3] = 32'h2C; tp_wd[3] = 32'h0;
    i = 0; guard = 0;
    req_funct3 = 3'b010;
    req_store = tp_st[0]; req_addr = tp_addr[0]; req_wdata = tp_wd[0];
    req_valid = 1'b1;
    while (i < 4 && guard < 40) begin
      rdy = req_ready;
      @(posedge clk); #1;
      guard++;
      if (resp_valid) resp_q.push_back(resp_rdata);
      if (rdy) begin
        acc_t[i] = cyc;
        i++;
        if (i < 4) begin
          req_store = tp_st[i]; req_addr = tp_addr[i]; req_wdata = tp_wd[i];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (resp_valid) resp_q.push_back(resp_rdata);
    end
    chk("tp_accepts", i, 4);
    if (i == 4) begin
      chk("tp_gap1", acc_t[1] - acc_t[0], 3);
      chk("tp_gap2", acc_t[2] - acc_t[1], 3);
      chk("tp_gap3", acc_t[3] - acc_t[2], 3);
    end
    chk("tp_resp_cnt", resp_q.size(), 4);
    if (resp_q.size() == 4) begin
      chk("tp_sw0_rdata", resp_q[0], 32'h0);
      chk("tp_lw1_rdata", resp_q[1], 32'h11112222);
      chk("tp_lw3_rdata", resp_q[3], 32'h33334444);
    end

    // Asynchronous reset in the middle of a store's access cycle
    wait_ready("rst_mid");
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_pre_wr", {31'h0, mem_wr_en}, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_wr_en", {31'h0, mem_wr_en}, 32'h1);
    chk("rst_mid_cs", {31'h0, mem_chip_select}, 32'h1);
    chk("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_no_resp", {31'h0, resp_valid}, 32'h0);
    run_req("post_rst_lw_8", 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hABCD7F01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
